// File: rtl/mul_issue_ctrl.sv
// Operand FIFO + issue/collect sequencer in front of shift_add_multiplier.
// Define MUL_ISSUE_TIMEOUT_EN to enable the wait-state watchdog and the sticky err flag.
module mul_issue_ctrl #(
  parameter int MUL_WIDTH      = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [MUL_WIDTH-1:0]   in_a,
  input  logic [MUL_WIDTH-1:0]   in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*MUL_WIDTH-1:0] out_data,
  output logic                   mul_start,
  output logic                   mul_sign,
  output logic [MUL_WIDTH-1:0]   mul_data_in1,
  output logic [MUL_WIDTH-1:0]   mul_data_in2,
  input  logic [2*MUL_WIDTH-1:0] mul_data_out,
  input  logic                   mul_ready,
  output logic                   busy,
  output logic                   err,
  output logic [1:0]             dbg_state
);

  // Handshakes: a transfer happens on a clock edge where valid && ready are both high;
  // valid and its payload hold until that edge, and ready never depends on valid.

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 2 * MUL_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_LOW  = 2'd2,
    S_WAIT_HIGH = 2'd3
  } state_t;

  logic [EW-1:0]          r_mem [FIFO_DEPTH];
  logic [AW:0]            r_wr_ptr;
  logic [AW:0]            r_rd_ptr;
  state_t                 r_state;
  logic                   r_mul_start;
  logic                   r_mul_sign;
  logic [MUL_WIDTH-1:0]   r_a;
  logic [MUL_WIDTH-1:0]   r_b;
  logic                   r_out_valid;
  logic [2*MUL_WIDTH-1:0] r_out_data;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_slot_free;
  logic          w_capture;
  logic          w_timeout;
  logic [EW-1:0] w_head;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push      = in_valid && !w_full;
  assign w_pop       = (r_state == S_IDLE) && !w_empty && mul_ready;
  assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_capture   = (r_state == S_WAIT_HIGH) && mul_ready && w_slot_free;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {in_sign, in_a, in_b};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

`ifdef MUL_ISSUE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_tmo_cnt;
  logic          r_err;
  logic          w_waiting;

  // A stall on a full output slot is not waiting on the multiplier, so it does not count.
  assign w_waiting = ((r_state == S_WAIT_LOW)  &&  mul_ready) ||
                     ((r_state == S_WAIT_HIGH) && !mul_ready);
  assign w_timeout = w_waiting && (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_timeout) r_err <= 1'b1;
      if ((r_state == S_ISSUE) || ((r_state == S_WAIT_LOW) && !mul_ready) || w_timeout) begin
        r_tmo_cnt <= '0;
      end else if (w_waiting) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mul_start <= 1'b0;
      r_mul_sign  <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_mul_start <= 1'b0;
      // A capture in the same cycle as a drain keeps the slot full with the new product.
      if (w_capture) begin
        r_out_valid <= 1'b1;
        r_out_data  <= mul_data_out;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_mul_sign, r_a, r_b} <= w_head;
            r_mul_start            <= 1'b1;
            r_state                <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT_LOW;
        S_WAIT_LOW: begin
          if (w_timeout)      r_state <= S_IDLE;
          else if (!mul_ready) r_state <= S_WAIT_HIGH;
        end
        S_WAIT_HIGH: begin
          if (w_timeout || w_capture) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = !w_full;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign mul_start    = r_mul_start;
  assign mul_sign     = r_mul_sign;
  assign mul_data_in1 = r_a;
  assign mul_data_in2 = r_b;
  assign busy         = (r_state != S_IDLE) || !w_empty;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl with a behavioural shift-add multiplier model and a product scoreboard.
`timescale 1ns/1ps
module tb_mul_issue_ctrl;
  localparam int W  = 4;
  localparam int PW = 2 * W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WLOW   = 2'd2;
  localparam logic [1:0] ST_WHIGH  = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sign = 1'b0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [PW-1:0] out_data;
  logic          mul_start;
  logic          mul_sign;
  logic [W-1:0]  mul_data_in1;
  logic [W-1:0]  mul_data_in2;
  logic [PW-1:0] mul_data_out;
  logic          mul_ready;
  logic          busy;
  logic          err;
  logic [1:0]    dbg_state;

  logic [PW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            start_cnt = 0;

  mul_issue_ctrl #(.MUL_WIDTH(W), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mul_start(mul_start), .mul_sign(mul_sign),
    .mul_data_in1(mul_data_in1), .mul_data_in2(mul_data_in2),
    .mul_data_out(mul_data_out), .mul_ready(mul_ready),
    .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- multiplier model ----------------
  logic          m_ready = 1'b1;
  logic [PW-1:0] m_out = '0;
  int            m_cnt = 0;
  logic          m_sign = 1'b0;
  logic [W-1:0]  m_a = '0;
  logic [W-1:0]  m_b = '0;
  logic          m_stuck = 1'b0;

  function automatic logic [PW-1:0] mul_fn(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [PW-1:0] xa, xb;
    xa = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    xb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return xa * xb;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ready <= 1'b1;
      m_out   <= '0;
      m_cnt   <= 0;
    end else if (m_ready) begin
      if (mul_start && !m_stuck) begin
        m_ready <= 1'b0;
        m_cnt   <= $urandom_range(2 * W + 1, W);
        m_sign  <= mul_sign;
        m_a     <= mul_data_in1;
        m_b     <= mul_data_in2;
      end
    end else begin
      if (m_cnt <= 1) begin
        m_ready <= 1'b1;
        m_out   <= mul_fn(m_sign, m_a, m_b);
      end
      m_cnt <= m_cnt - 1;
    end
  end

  assign mul_ready    = m_ready;
  assign mul_data_out = m_out;

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    n_fail++;
    $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (mul_start) start_cnt++;
      if (!m_ready) begin
        check("operand1_stable", mul_data_in1, m_a);
        check("operand2_stable", mul_data_in2, m_b);
        check("sign_stable", mul_sign, m_sign);
      end
      if (out_valid) begin
        if (exp_q.size() == 0)  fail("spurious_product", out_data, 0);
        else if (out_ready)     check("product", out_data, exp_q.pop_front());
        else                    check("held_product", out_data, exp_q[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [PW-1:0] e, input bit has_exp);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_sign  = s;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) fail("push_timeout", 0, 1);
    else if (has_exp) exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy || out_valid) && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() != 0 || busy || out_valid) fail(name, exp_q.size(), 0);
  endtask

  task automatic wait_state(input logic [1:0] st, input string name);
    int n;
    n = 0;
    while (dbg_state != st && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (dbg_state != st) fail(name, dbg_state, st);
  endtask

  // Directed vectors: {sign, a, b, expected product}
  logic [2*W+PW:0] full_vec [6];
  logic [2*W+PW:0] sgn_vec  [8];

  initial begin
    full_vec[0] = {1'b0, 4'h1, 4'h1, 8'h01};
    full_vec[1] = {1'b0, 4'hF, 4'hF, 8'hE1};
    full_vec[2] = {1'b1, 4'h7, 4'h7, 8'h31};
    full_vec[3] = {1'b1, 4'hF, 4'h1, 8'hFF};
    full_vec[4] = {1'b0, 4'hA, 4'h3, 8'h1E};
    full_vec[5] = {1'b1, 4'h8, 4'h7, 8'hC8};
    sgn_vec[0]  = {1'b1, 4'h3, 4'h4, 8'h0C};
    sgn_vec[1]  = {1'b1, 4'hE, 4'h5, 8'hF6};
    sgn_vec[2]  = {1'b1, 4'h7, 4'h8, 8'hC8};
    sgn_vec[3]  = {1'b1, 4'h9, 4'h9, 8'h31};
    sgn_vec[4]  = {1'b1, 4'h0, 4'h5, 8'h00};
    sgn_vec[5]  = {1'b1, 4'hF, 4'hF, 8'h01};
    sgn_vec[6]  = {1'b1, 4'h6, 4'hB, 8'hE2};
    sgn_vec[7]  = {1'b1, 4'h4, 4'hC, 8'hF0};
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [2*W+PW:0] v;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_sign", mul_sign, 0);
    check("rst_in1", mul_data_in1, 0);
    check("rst_in2", mul_data_in2, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;

    // unsigned 3*5, with issue timing
    start_cnt = 0;
    push(1'b0, 4'h3, 4'h5, 8'h0F, 1'b1);
    @(negedge clk);
    check("start_t1", mul_start, 0);
    @(negedge clk);
    check("start_t2", mul_start, 1);
    check("t2_in1", mul_data_in1, 3);
    check("t2_in2", mul_data_in2, 5);
    check("t2_sign", mul_sign, 0);
    @(negedge clk);
    check("mul_busy_t3", mul_ready, 0);
    check("start_t3", mul_start, 0);
    wait_drain("drain_unsigned");
    check("single_start", start_cnt, 1);
    @(posedge clk); #1;

    // signed
    push(1'b1, 4'hD, 4'h5, 8'hF1, 1'b1);
    wait_drain("drain_signed1");
    @(posedge clk); #1;
    push(1'b1, 4'h8, 4'h8, 8'h40, 1'b1);
    wait_drain("drain_signed2");
    @(posedge clk); #1;

    // full FIFO under output backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      v = full_vec[i];
      push(v[2*W+PW], v[2*W+PW-1:PW+W], v[PW+W-1:PW], v[PW-1:0], 1'b1);
    end
    repeat (25) @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    check("full_state", dbg_state, ST_WHIGH);
    check("full_busy", busy, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("drain_full");
    @(posedge clk); #1;

    // continuous drain, signed stream
    for (int i = 0; i < 8; i++) begin
      v = sgn_vec[i];
      push(v[2*W+PW], v[2*W+PW-1:PW+W], v[PW+W-1:PW], v[PW-1:0], 1'b1);
    end
    wait_drain("drain_stream");
    @(posedge clk); #1;

    // reset in WAIT_HIGH discards the in-flight product
    push(1'b0, 4'h9, 4'h9, 8'h00, 1'b0);
    wait_state(ST_WHIGH, "reach_wait_high");
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post_rst_out_valid", out_valid, 0);
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_start", mul_start, 0);
      check("post_rst_state", dbg_state, ST_IDLE);
    end
    @(posedge clk); #1;
    push(1'b0, 4'h2, 4'h7, 8'h0E, 1'b1);
    wait_drain("drain_after_reset");
    @(posedge clk); #1;

`ifdef MUL_ISSUE_TIMEOUT_EN
    // watchdog with a multiplier that never drops ready
    m_stuck = 1'b1;
    push(1'b0, 4'h1, 4'h1, 8'h00, 1'b0);
    wait_state(ST_WLOW, "reach_wait_low");
    repeat (63) @(negedge clk);
    check("tmo_err_early", err, 0);
    check("tmo_state_early", dbg_state, ST_WLOW);
    @(negedge clk);
    check("tmo_err", err, 1);
    check("tmo_state", dbg_state, ST_IDLE);
    check("tmo_out_valid", out_valid, 0);
    @(posedge clk); #1;
    m_stuck = 1'b0;
    repeat (5) @(negedge clk);
    check("tmo_err_sticky", err, 1);
    check("tmo_no_product", out_valid, 0);
`else
    check("err_tied_low", err, 0);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_checks++;
    n_fail++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
